regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file: two bypassed combinational read ports, one write port,
// and a reserve/release busy scoreboard. Define REGFILE_ZERO_REG_EN to hard-wire r0 to zero.
module regfile_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic              rsv_err_q, rsv_err_d;
  logic [CntW-1:0]   busy_count_q, busy_count_d;

  // Effective strobes: with the zero register, anything aimed at r0 is dropped here.
  logic wr_eff, rsv_eff;
`ifdef REGFILE_ZERO_REG_EN
  assign wr_eff  = wr_en && (wr_addr != '0);
  assign rsv_eff = rsv_en && (rsv_addr != '0);
`else
  assign wr_eff  = wr_en;
  assign rsv_eff = rsv_en;
`endif

  logic wr_hit_a, wr_hit_b, rsv_hit_a, rsv_hit_b;
  assign wr_hit_a  = wr_eff && (wr_addr == rd_addr_a);
  assign wr_hit_b  = wr_eff && (wr_addr == rd_addr_b);
  assign rsv_hit_a = rsv_eff && (rsv_addr == rd_addr_a);
  assign rsv_hit_b = rsv_eff && (rsv_addr == rd_addr_b);

  always_comb begin
    rd_data_a = wr_hit_a ? wr_data : regs_q[rd_addr_a];
    rd_data_b = wr_hit_b ? wr_data : regs_q[rd_addr_b];
    // A delivering write releases the register this cycle unless a new producer claims it.
    busy_a    = busy_q[rd_addr_a] && !(wr_hit_a && !rsv_hit_a);
    busy_b    = busy_q[rd_addr_b] && !(wr_hit_b && !rsv_hit_b);
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_eff) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_eff) begin
      busy_d[rsv_addr] = 1'b1;
    end
    rsv_err_d = rsv_eff && busy_q[rsv_addr] && !(wr_eff && (wr_addr == rsv_addr));
    busy_count_d = '0;
    for (int i = 0; i < Depth; i++) begin
      busy_count_d = busy_count_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      rsv_err_q    <= 1'b0;
      busy_count_q <= '0;
    end else begin
      if (wr_eff) begin
        regs_q[wr_addr] <= wr_data;
      end
      busy_q       <= busy_d;
      rsv_err_q    <= rsv_err_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign rsv_err    = rsv_err_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, rsv_addr = '0;
  logic [15:0] rd_data_a, rd_data_b, wr_data = '0;
  logic        busy_a, busy_b, wr_en = 1'b0, rsv_en = 1'b0, rsv_err;
  logic [4:0]  busy_count;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_err    (rsv_err),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state after each edge.
  logic [15:0] m_mem [16];
  logic [15:0] m_busy;
  logic        m_err;

  function automatic bit is_zero_reg(input logic [3:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a == 4'd0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= '0;
      m_busy <= '0;
      m_err  <= 1'b0;
    end else begin
      m_err <= rsv_en && !is_zero_reg(rsv_addr) && m_busy[rsv_addr]
               && !(wr_en && wr_addr == rsv_addr);
      if (wr_en && !is_zero_reg(wr_addr)) begin
        m_mem[wr_addr]  <= wr_data;
        m_busy[wr_addr] <= 1'b0;
      end
      if (rsv_en && !is_zero_reg(rsv_addr)) m_busy[rsv_addr] <= 1'b1;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [3:0] a);
    if (is_zero_reg(a)) return 16'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    bit writing, reserving;
    writing   = wr_en && wr_addr == a && !is_zero_reg(a);
    reserving = rsv_en && rsv_addr == a && !is_zero_reg(a);
    return m_busy[a] && !(writing && !reserving);
  endfunction

  function automatic logic [4:0] exp_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return 5'(n);
  endfunction

  task automatic drive_idle();
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
    drive_idle();
    checks++;
    if (busy_count !== 5'd0 || rsv_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: busy_count=%0d rsv_err=%b required 0/0", busy_count, rsv_err);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      rd_addr_b = 4'(15 - a);
      #1;
      checks++;
      if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_read a=%0d: data=%h/%h busy=%b/%b required 0", a, rd_data_a,
                 rd_data_b, busy_a, busy_b);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_a = 4'd5;
    #1;
    checks++;
    if (rd_data_a !== 16'hBEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h required BEEF", rd_data_a);
    end
    drive_idle();
    checks++;
    if (rd_data_a !== 16'hBEEF) begin
      errors++;
      $display("FAIL bypass_stored: got %h required BEEF", rd_data_a);
    end
  endtask

  task automatic test_reserve();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 4'd3; rd_addr_a = 4'd3;
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reserve_latency: busy_a=%b required 0", busy_a);
    end
    drive_idle();
    checks++;
    if (busy_a !== 1'b1 || busy_count !== 5'd1) begin
      errors++;
      $display("FAIL reserve_visible: busy_a=%b count=%0d required 1/1", busy_a, busy_count);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h0042;
    #1;
    checks++;
    if (busy_a !== 1'b0 || rd_data_a !== 16'h0042) begin
      errors++;
      $display("FAIL release_write: busy_a=%b data=%h required 0/0042", busy_a, rd_data_a);
    end
    drive_idle();
    checks++;
    if (busy_count !== 5'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL release_count: count=%0d busy_a=%b required 0/0", busy_count, busy_a);
    end
  endtask

  task automatic test_double_reserve();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 4'd7;
    @(negedge clk);
    #1;
    checks++;
    if (rsv_err !== 1'b0) begin
      errors++;
      $display("FAIL double_rsv_first: rsv_err=%b required 0", rsv_err);
    end
    drive_idle();
    checks++;
    if (rsv_err !== 1'b1 || busy_count !== 5'd1) begin
      errors++;
      $display("FAIL double_rsv_err: rsv_err=%b count=%0d required 1/1", rsv_err, busy_count);
    end
    drive_idle();
    checks++;
    if (rsv_err !== 1'b0) begin
      errors++;
      $display("FAIL double_rsv_pulse: rsv_err=%b required 0", rsv_err);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
    drive_idle();
  endtask

  task automatic test_write_reserve_same();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hA5A5;
    rsv_en = 1'b1; rsv_addr = 4'd9; rd_addr_a = 4'd9;
    #1;
    checks++;
    if (rd_data_a !== 16'hA5A5 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsv_bypass: data=%h busy=%b required A5A5/0", rd_data_a, busy_a);
    end
    drive_idle();
    checks++;
    if (rd_data_a !== 16'hA5A5 || busy_a !== 1'b1 || rsv_err !== 1'b0 || busy_count !== 5'd1) begin
      errors++;
      $display("FAIL wr_rsv_after: data=%h busy=%b err=%b count=%0d required A5A5/1/0/1",
               rd_data_a, busy_a, rsv_err, busy_count);
    end
    // Register already busy: a write+reserve hand-off is not a hazard.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1111; rsv_en = 1'b1; rsv_addr = 4'd9;
    drive_idle();
    checks++;
    if (rd_data_a !== 16'h1111 || rsv_err !== 1'b0 || busy_count !== 5'd1) begin
      errors++;
      $display("FAIL wr_rsv_handoff: data=%h err=%b count=%0d required 1111/0/1", rd_data_a,
               rsv_err, busy_count);
    end
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h7777; rd_addr_b = 4'd2;
    drive_idle();
    checks++;
    if (rd_data_b !== 16'h0 || busy_count !== 5'd0 || rd_data_a !== 16'h0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: r2=%h count=%0d r9=%h busy9=%b required 0/0/0/0", rd_data_b,
               busy_count, rd_data_a, busy_a);
    end
  endtask

  task automatic test_reg0();
    logic [15:0] exp_data;
    logic        exp_b;
    logic [4:0]  exp_c;
`ifdef REGFILE_ZERO_REG_EN
    exp_data = 16'h0; exp_b = 1'b0; exp_c = 5'd0;
`else
    exp_data = 16'hFFFF; exp_b = 1'b1; exp_c = 5'd1;
`endif
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 4'd0;
    rd_addr_a = 4'd0;
    #1;
    checks++;
    if (rd_data_a !== exp_data || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reg0_bypass: data=%h busy=%b required %h/0", rd_data_a, busy_a, exp_data);
    end
    drive_idle();
    checks++;
    if (rd_data_a !== exp_data || busy_a !== exp_b || busy_count !== exp_c || rsv_err !== 1'b0) begin
      errors++;
      $display("FAIL reg0_after: data=%h busy=%b count=%0d err=%b required %h/%b/%0d/0",
               rd_data_a, busy_a, busy_count, rsv_err, exp_data, exp_b, exp_c);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0;
    drive_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 39) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      rsv_en    = ($urandom_range(0, 2) == 0);
      wr_addr   = 4'($urandom_range(0, 15));
      rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_addr_b = ($urandom_range(0, 2) == 0) ? rsv_addr : 4'($urandom_range(0, 15));
      wr_data   = 16'($urandom);
      #1;
      checks++;
      if (rsv_err !== m_err || busy_count !== exp_count()) begin
        errors++;
        $display("FAIL rand_reg n=%0d: err=%b count=%0d required %b/%0d", n, rsv_err,
                 busy_count, m_err, exp_count());
      end
      if (!rst) begin
        checks++;
        if (rd_data_a !== exp_rd(rd_addr_a) || rd_data_b !== exp_rd(rd_addr_b)
            || busy_a !== exp_busy(rd_addr_a) || busy_b !== exp_busy(rd_addr_b)) begin
          errors++;
          $display("FAIL rand_comb n=%0d: data=%h/%h busy=%b/%b required %h/%h %b/%b", n,
                   rd_data_a, rd_data_b, busy_a, busy_b, exp_rd(rd_addr_a), exp_rd(rd_addr_b),
                   exp_busy(rd_addr_a), exp_busy(rd_addr_b));
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_bypass();
    test_reserve();
    test_double_reserve();
    test_write_reserve_same();
    test_reg0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
